// File: rtl/rom_fetch_sequencer_if.sv
// ROM read bus plus instruction stream between the fetch sequencer (master)
// and the ROM/consumer side (slave).
interface rom_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] ROM_ADDRESS;
    logic                  ROM_ENABLE;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic [DATA_WIDTH-1:0] INSTR_DATA;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  INSTR_LAST;

    modport master (
        output ROM_ADDRESS,
        output ROM_ENABLE,
        input  ROM_DATA,
        output INSTR_DATA,
        output INSTR_VALID,
        output INSTR_LAST,
        input  INSTR_READY
    );

    modport slave (
        input  ROM_ADDRESS,
        input  ROM_ENABLE,
        output ROM_DATA,
        input  INSTR_DATA,
        input  INSTR_VALID,
        input  INSTR_LAST,
        output INSTR_READY
    );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// Walks START..END for ITERATIONS passes over a 1-cycle synchronous ROM and
// streams the words through a 2-entry skid FIFO with valid/ready backpressure.
module rom_fetch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int ITER_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [ADDR_WIDTH-1:0] END_ADDR,
    input  logic [ITER_WIDTH-1:0] ITERATIONS,
    output logic                  BUSY,
    output logic                  DONE,
    rom_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [ADDR_WIDTH-1:0] end_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ITER_WIDTH-1:0] pass_q;
    logic                  inflight_q;
    logic                  tag_q;
    logic                  done_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            last_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  last_word;
    logic                  at_end;
    logic [2:0]            credit_used;
    logic [2:0]            credit_limit;

    // Credit counts words already buffered plus the one in the ROM pipe, so a
    // read is only issued when its word is guaranteed a FIFO slot.
    always_comb begin
        pop          = (cnt_q != 2'd0) && bus.INSTR_READY;
        push         = inflight_q;
        credit_used  = {1'b0, cnt_q} + {2'b00, inflight_q};
        credit_limit = 3'd2 + {2'b00, pop};
        issue        = (state_q == S_FETCH) && !ABORT && (credit_used < credit_limit);
        at_end       = (addr_q == end_q);
        last_word    = at_end && (pass_q == ITER_WIDTH'(1));
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            end_q      <= '0;
            addr_q     <= '0;
            pass_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else if (ABORT) begin
            state_q    <= S_IDLE;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            cnt_q      <= cnt_d;
            inflight_q <= issue;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            if (issue) tag_q <= last_word;

            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        start_q <= START_ADDR;
                        end_q   <= END_ADDR;
                        addr_q  <= START_ADDR;
                        pass_q  <= ITERATIONS;
                        state_q <= (ITERATIONS == '0) ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        if (at_end) begin
                            addr_q <= start_q;
                            pass_q <= pass_q - ITER_WIDTH'(1);
                            if (pass_q == ITER_WIDTH'(1)) state_q <= S_DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if ((cnt_q == 2'd0) && !inflight_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Payload storage needs no reset; visibility is qualified by the count.
    always_ff @(posedge CLK) begin
        if (push && !ABORT) begin
            data_q[wr_ptr_q] <= bus.ROM_DATA;
            last_q[wr_ptr_q] <= tag_q;
        end
    end

    assign bus.ROM_ADDRESS = addr_q;
    assign bus.ROM_ENABLE  = issue;
    assign bus.INSTR_VALID = (cnt_q != 2'd0);
    assign bus.INSTR_DATA  = (cnt_q != 2'd0) ? data_q[rd_ptr_q] : '0;
    assign bus.INSTR_LAST  = (cnt_q != 2'd0) && last_q[rd_ptr_q];
    assign BUSY            = (state_q != S_IDLE);
    assign DONE            = done_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed + randomized bench: ROM model, expected word/address queues built
// from the range/pass rules, and a per-cycle stream monitor.
module tb_rom_fetch_sequencer;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int IW = 8;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [AW-1:0] START_ADDR = '0;
    logic [AW-1:0] END_ADDR = '0;
    logic [IW-1:0] ITERATIONS = '0;
    logic          BUSY;
    logic          DONE;

    rom_fetch_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rom_fetch_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ITER_WIDTH(IW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .ABORT      (ABORT),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .ITERATIONS (ITERATIONS),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .bus        (bus.master)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] rom_q = '0;
    always @(posedge CLK) if (bus.ROM_ENABLE) rom_q <= mem[bus.ROM_ADDRESS];
    assign bus.ROM_DATA = rom_q;

    int total = 0;
    int bad = 0;
    logic [DW:0]   exp_q [$];
    logic [AW-1:0] eaddr_q [$];
    int issued = 0, popped = 0, done_cnt = 0, last_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected stream: each pass walks s..e with modulo wrap; LAST on the final word only.
    task automatic load_model(input logic [AW-1:0] s, input logic [AW-1:0] e, input int it);
        logic [AW-1:0] a;
        for (int p = 0; p < it; p++) begin
            a = s;
            forever begin
                exp_q.push_back({(p == it - 1) && (a == e), mem[a]});
                eaddr_q.push_back(a);
                if (a == e) break;
                a = a + 1'b1;
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        eaddr_q.delete();
        issued = 0;
        popped = 0;
    endtask

    task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [IW-1:0] it);
        START_ADDR = s;
        END_ADDR   = e;
        ITERATIONS = it;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd_ready);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            bus.INSTR_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.ROM_ENABLE) begin
                issued++;
                if (eaddr_q.size() == 0) check("rom_addr_unexpected", 1, 0);
                else check("rom_addr", bus.ROM_ADDRESS, eaddr_q.pop_front());
            end
            if (bus.INSTR_VALID && bus.INSTR_READY) begin
                popped++;
                if (bus.INSTR_LAST) last_cnt++;
                if (exp_q.size() == 0) check("word_unexpected", 1, 0);
                else check("word", {bus.INSTR_LAST, bus.INSTR_DATA}, exp_q.pop_front());
            end
            if (prev_stall)
                check("stall_hold", {bus.INSTR_VALID, bus.INSTR_LAST, bus.INSTR_DATA}, {1'b1, prev_word});
            prev_stall = bus.INSTR_VALID && !bus.INSTR_READY && !ABORT;
            prev_word  = {bus.INSTR_LAST, bus.INSTR_DATA};
            check("occupancy_le2", 32'((issued - popped) <= 2), 1);
            if (DONE) begin
                done_cnt++;
                check("done_busy_low", BUSY, 0);
                check("done_all_words", exp_q.size(), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int l0, p0, d0;
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        bus.INSTR_READY = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_rom_addr", bus.ROM_ADDRESS, 0);
        check("rst_rom_en", bus.ROM_ENABLE, 0);
        check("rst_valid", bus.INSTR_VALID, 0);
        check("rst_data", bus.INSTR_DATA, 0);
        check("rst_last", bus.INSTR_LAST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RESET_N = 1'b1;
        tick();

        // T1: simple range, full throughput, latency checks
        bus.INSTR_READY = 1'b1;
        l0 = last_cnt;
        load_model(6'd4, 6'd7, 1);
        start_run(6'd4, 6'd7, 8'd1);
        check("t1_en_e0", bus.ROM_ENABLE, 1);
        check("t1_addr_e0", bus.ROM_ADDRESS, 4);
        check("t1_busy", BUSY, 1);
        check("t1_valid_c1", bus.INSTR_VALID, 0);
        tick();
        check("t1_addr_c2", bus.ROM_ADDRESS, 5);
        check("t1_valid_c2", bus.INSTR_VALID, 0);
        tick();
        check("t1_valid_c3", bus.INSTR_VALID, 1);
        check("t1_first_word", bus.INSTR_DATA, mem[4]);
        wait_done("t1_done", 50, 1'b0);
        check("t1_last_count", last_cnt - l0, 1);
        tick();

        // T2: wrap through address 0, two passes
        l0 = last_cnt; p0 = popped;
        load_model(6'd62, 6'd1, 2);
        start_run(6'd62, 6'd1, 8'd2);
        wait_done("t2_done", 80, 1'b0);
        check("t2_words", popped - p0, 8);
        check("t2_last_count", last_cnt - l0, 1);
        tick();

        // T3: stall consumer, ROM reads must stop at two outstanding words
        clear_model();
        bus.INSTR_READY = 1'b0;
        load_model(6'd0, 6'd9, 1);
        start_run(6'd0, 6'd9, 8'd1);
        repeat (8) tick();
        check("t3_stall_en", bus.ROM_ENABLE, 0);
        check("t3_stall_valid", bus.INSTR_VALID, 1);
        check("t3_buffered", issued - popped, 2);
        check("t3_head_data", bus.INSTR_DATA, mem[0]);
        wait_done("t3_done", 100, 1'b0);
        check("t3_words", popped, 10);
        tick();

        // T4: full address space, three passes, random backpressure
        clear_model();
        l0 = last_cnt;
        load_model(6'd0, 6'd63, 3);
        start_run(6'd0, 6'd63, 8'd3);
        wait_done("t4_done", 3000, 1'b1);
        check("t4_words", popped, 192);
        check("t4_last_count", last_cnt - l0, 1);
        bus.INSTR_READY = 1'b1;
        tick();

        // T5: abort with two buffered words, then an immediate fresh run
        clear_model();
        bus.INSTR_READY = 1'b0;
        load_model(6'd20, 6'd30, 1);
        start_run(6'd20, 6'd30, 8'd1);
        repeat (3) tick();
        check("t5_buffered", issued - popped, 2);
        d0 = done_cnt;
        ABORT = 1'b1;
        #1;
        check("t5_abort_en", bus.ROM_ENABLE, 0);
        tick();
        ABORT = 1'b0;
        clear_model();
        check("t5_valid_after", bus.INSTR_VALID, 0);
        check("t5_busy_after", BUSY, 0);
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        check("t5_abort_wins", BUSY, 0);
        bus.INSTR_READY = 1'b1;
        p0 = popped; l0 = last_cnt;
        load_model(6'd10, 6'd10, 1);
        start_run(6'd10, 6'd10, 8'd1);
        wait_done("t5_done", 40, 1'b0);
        check("t5_no_abort_done", done_cnt - d0, 1);
        check("t5_single_word", popped - p0, 1);
        check("t5_single_last", last_cnt - l0, 1);
        tick();

        // T6: zero iterations, START while busy ignored, async reset mid-run
        start_run(6'd5, 6'd9, 8'd0);
        check("t6_busy", BUSY, 1);
        check("t6_no_en", bus.ROM_ENABLE, 0);
        START = 1'b1; ITERATIONS = 8'd4;
        tick();
        START = 1'b0;
        check("t6_done", DONE, 1);
        check("t6_done_busy", BUSY, 0);
        tick();
        check("t6_done_pulse", DONE, 0);
        check("t6_start_ignored", BUSY, 0);

        clear_model();
        d0 = done_cnt;
        load_model(6'd0, 6'd63, 1);
        start_run(6'd0, 6'd63, 8'd1);
        repeat (5) tick();
        #1;
        RESET_N = 1'b0;
        #1;
        check("t6_rst_addr", bus.ROM_ADDRESS, 0);
        check("t6_rst_en", bus.ROM_ENABLE, 0);
        check("t6_rst_valid", bus.INSTR_VALID, 0);
        check("t6_rst_data", bus.INSTR_DATA, 0);
        check("t6_rst_last", bus.INSTR_LAST, 0);
        check("t6_rst_busy", BUSY, 0);
        check("t6_rst_done", DONE, 0);
        clear_model();
        tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        check("t6_no_done_after_rst", done_cnt - d0, 0);
        check("total_done_pulses", done_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
